// File: rtl/dmem_responder.sv
// Y86 data-memory responder: byte-addressed little-endian storage answering 8-byte loads/stores
// after a fixed LATENCY, with out-of-range accesses flagged on resp_error.
module dmem_responder #(
  parameter int unsigned DEPTH   = 1024,
  parameter int unsigned LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_rdata,
  output logic        resp_error
);

  localparam int unsigned AW = $clog2(DEPTH);

  typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

  state_e          state_q;
  logic [3:0]      cnt_q;
  logic            write_q;
  logic            err_q;
  logic [AW-1:0]   addr_q;
  logic [63:0]     wdata_q;
  logic [7:0]      mem [DEPTH];
  logic            commit;
  logic [63:0]     rd_word;

  // cnt_q counts the edges still to go; the edge leaving cnt_q==1 is edge T+LATENCY.
  assign commit    = (state_q == StBusy) && (cnt_q == 4'd1);
  assign req_ready = (state_q == StIdle) && !rst;

  always_comb begin
    rd_word = '0;
    for (int i = 0; i < 8; i++) begin
      rd_word[8*i +: 8] = mem[addr_q + AW'(i)];
    end
  end

  // Storage is deliberately outside the reset domain.
  always_ff @(posedge clk) begin
    if (commit && write_q && !err_q) begin
      for (int i = 0; i < 8; i++) begin
        mem[addr_q + AW'(i)] <= wdata_q[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      write_q    <= 1'b0;
      err_q      <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_error <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req_valid) begin
            write_q <= req_write;
            addr_q  <= req_addr[AW-1:0];
            wdata_q <= req_wdata;
            err_q   <= req_addr > 64'(DEPTH - 8);
            cnt_q   <= 4'(LATENCY);
            state_q <= StBusy;
          end
        end
        StBusy: begin
          if (cnt_q == 4'd1) begin
            state_q    <= StResp;
            resp_valid <= 1'b1;
            resp_rdata <= (write_q || err_q) ? '0 : rd_word;
            resp_error <= err_q;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        StResp: begin
          if (resp_ready) begin
            state_q    <= StIdle;
            resp_valid <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
